// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - sequencer state type and offset-binary helpers for codec_frame_sequencer
package codec_pkg;

   typedef enum logic [2:0] {IDLE, LAUNCH, ARM, BUSY, CAPTURE} seq_state_t;

   localparam int MAX_SAMPLE_WIDTH = 32;

   // Flipping bit w-1 maps a w-bit two's complement value onto offset binary and back.
   function automatic logic [MAX_SAMPLE_WIDTH-1:0] to_offset_bin(
      input logic [MAX_SAMPLE_WIDTH-1:0] x,
      input int                          w
   );
      return x ^ (MAX_SAMPLE_WIDTH'(1) << (w - 1));
   endfunction

   function automatic logic [MAX_SAMPLE_WIDTH-1:0] from_offset_bin(
      input logic [MAX_SAMPLE_WIDTH-1:0] x,
      input int                          w
   );
      return x ^ (MAX_SAMPLE_WIDTH'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/codec_frame_sequencer_timer.sv
// rtl/codec_frame_sequencer_timer.sv - modulo-FRAME_PERIOD frame timer, tick on wrap to 0
module frame_timer #(
   parameter int FRAME_PERIOD = 1000
) (
   input  logic clk,
   input  logic nrst,
   input  logic en_i,
   output logic tick_o
);

   localparam int CW = $clog2(FRAME_PERIOD);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;

   assign wrap = (cnt_q == CW'(FRAME_PERIOD - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i & wrap;

endmodule

// File: rtl/codec_frame_sequencer.sv
// rtl/codec_frame_sequencer.sv - per-frame SPI launch, DAC word formatting, ADC unpacking
// Optional sticky dropped-tick flag overrun_o under CODEC_OVERRUN_EN.
module codec_frame_sequencer
   import codec_pkg::*;
#(
   parameter int                                  SAMPLE_WIDTH = 16,
   parameter int                                  TX_WIDTH     = 24,
   parameter int                                  RX_WIDTH     = 24,
   parameter int                                  FRAME_PERIOD = 1000,
   parameter logic [TX_WIDTH-SAMPLE_WIDTH-1:0]    DAC_CMD      = 8'h30,
   parameter int                                  RX_SHIFT     = 0,
   parameter int                                  ARM_TIMEOUT  = 4
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    en_i,
   input  logic [SAMPLE_WIDTH-1:0] dac_sample_i,
   input  logic                    dac_valid_i,
   output logic                    dac_ready_o,
   output logic [SAMPLE_WIDTH-1:0] adc_sample_o,
   output logic                    adc_valid_o,
   output logic                    spi_cs_o,
   output logic [TX_WIDTH-1:0]     spi_tx_data_o,
   input  logic [RX_WIDTH-1:0]     spi_rx_data_i,
   input  logic                    spi_done_i,
`ifdef CODEC_OVERRUN_EN
   output logic                    frame_err_o,
   output logic                    overrun_o
`else
   output logic                    frame_err_o
`endif
);

   localparam int AW = $clog2(ARM_TIMEOUT + 1);

   seq_state_t              state_q, state_d;
   logic [SAMPLE_WIDTH-1:0] hold_q;
   logic [TX_WIDTH-1:0]     tx_q, tx_d;
   logic                    cs_q, cs_d;
   logic [AW-1:0]           arm_cnt_q, arm_cnt_d, arm_next;
   logic [SAMPLE_WIDTH-1:0] adc_sample_q, adc_sample_d;
   logic                    adc_valid_q, adc_valid_d;
   logic                    frame_err_q, frame_err_d;
   logic                    tick;
   logic                    unused_rx;

   frame_timer #(
      .FRAME_PERIOD(FRAME_PERIOD)
   ) u_frame_timer (
      .clk   (clk),
      .nrst  (nrst),
      .en_i  (en_i),
      .tick_o(tick)
   );

   assign unused_rx   = ^spi_rx_data_i;
   assign dac_ready_o = (state_q != LAUNCH);
   assign arm_next    = arm_cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      tx_d         = tx_q;
      cs_d         = cs_q;
      arm_cnt_d    = arm_cnt_q;
      adc_sample_d = adc_sample_q;
      adc_valid_d  = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick && spi_done_i) begin
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            tx_d      = {DAC_CMD, SAMPLE_WIDTH'(to_offset_bin(MAX_SAMPLE_WIDTH'(hold_q), SAMPLE_WIDTH))};
            cs_d      = 1'b0;
            arm_cnt_d = '0;
            state_d   = ARM;
         end
         ARM: begin
            // A controller that never acknowledges cs must not stall the frame cadence.
            if (!spi_done_i) begin
               state_d = BUSY;
            end else if (arm_next == AW'(ARM_TIMEOUT)) begin
               cs_d        = 1'b1;
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else begin
               arm_cnt_d = arm_next;
            end
         end
         BUSY: begin
            if (spi_done_i) begin
               cs_d    = 1'b1;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            adc_sample_d = SAMPLE_WIDTH'(from_offset_bin(
                              MAX_SAMPLE_WIDTH'(spi_rx_data_i[RX_SHIFT +: SAMPLE_WIDTH]), SAMPLE_WIDTH));
            adc_valid_d  = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q      <= IDLE;
         tx_q         <= '0;
         cs_q         <= 1'b1;
         arm_cnt_q    <= '0;
         adc_sample_q <= '0;
         adc_valid_q  <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         tx_q         <= tx_d;
         cs_q         <= cs_d;
         arm_cnt_q    <= arm_cnt_d;
         adc_sample_q <= adc_sample_d;
         adc_valid_q  <= adc_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Last accepted sample is re-sent when the delay core misses a frame.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         hold_q <= '0;
      end else if (dac_valid_i && dac_ready_o) begin
         hold_q <= dac_sample_i;
      end
   end

   assign spi_tx_data_o = tx_q;
   assign spi_cs_o      = cs_q;
   assign adc_sample_o  = adc_sample_q;
   assign adc_valid_o   = adc_valid_q;
   assign frame_err_o   = frame_err_q;

`ifdef CODEC_OVERRUN_EN
   logic overrun_q;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         overrun_q <= 1'b0;
      end else if (tick && ((state_q != IDLE) || !spi_done_i)) begin
         overrun_q <= 1'b1;
      end
   end

   assign overrun_o = overrun_q;
`endif

endmodule
